// File: rtl/vx_tex_dcr_queue.sv
// vx_tex_dcr_queue: in-order DCR write buffer that issues single-cycle write pulses only while the texture pipeline is idle
module vx_tex_dcr_queue #(
    parameter int DEPTH        = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int HOLD_ON_BUSY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    input  logic                         tex_idle,
    output logic                         out_write_valid,
    output logic [ADDR_WIDTH-1:0]        out_write_addr,
    output logic [DATA_WIDTH-1:0]        out_write_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  push, pop;

    assign in_ready        = count_q != CW'(DEPTH);
    assign push            = in_valid && in_ready;
    assign pop             = (count_q != '0) && (tex_idle || HOLD_ON_BUSY == 0);
    assign out_write_valid = out_valid_q;
    assign out_write_addr  = out_addr_q;
    assign out_write_data  = out_data_q;
    assign pending         = count_q;
    assign empty           = (count_q == '0) && !out_valid_q;

    // next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // entry storage, needs no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= in_addr;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // queue state and the registered write pulse; reset drops everything including a pulse in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= pop;
            if (pop) begin
                out_addr_q <= addr_mem_q[rd_ptr_q];
                out_data_q <= data_mem_q[rd_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_vx_tex_dcr_queue.sv
// tb_vx_tex_dcr_queue: scoreboard bench with a queue-based reference model and a decoupled output monitor
module tb_vx_tex_dcr_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        tex_idle = 1'b0;
    logic        out_write_valid;
    logic [11:0] out_write_addr;
    logic [31:0] out_write_data;
    logic [2:0]  pending;
    logic        empty;

    logic        nb_valid = 1'b0;
    logic [11:0] nb_addr = '0;
    logic [31:0] nb_data = '0;
    logic        nb_ready;
    logic        nb_idle = 1'b0;
    logic        nb_out_valid;
    logic [11:0] nb_out_addr;
    logic [31:0] nb_out_data;
    logic [2:0]  nb_pending;
    logic        nb_empty;

    int   passed = 0;
    int   total = 0;
    ent_t model_q[$];
    ent_t exp_q[$];
    logic pulse_now = 1'b0;
    logic [11:0] last_a = '0;
    logic [31:0] last_d = '0;

    vx_tex_dcr_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(12), .DATA_WIDTH(32), .HOLD_ON_BUSY(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_ready(in_ready), .tex_idle(tex_idle), .out_write_valid(out_write_valid),
        .out_write_addr(out_write_addr), .out_write_data(out_write_data), .pending(pending), .empty(empty)
    );

    vx_tex_dcr_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(12), .DATA_WIDTH(32), .HOLD_ON_BUSY(0)) dut_nb (
        .clk(clk), .reset(reset), .in_valid(nb_valid), .in_addr(nb_addr), .in_data(nb_data),
        .in_ready(nb_ready), .tex_idle(nb_idle), .out_write_valid(nb_out_valid),
        .out_write_addr(nb_out_addr), .out_write_data(nb_out_data), .pending(nb_pending), .empty(nb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // one clock of stimulus: check occupancy flags, drive inputs, then advance the reference model
    task automatic step(input logic v, input logic [11:0] a, input logic [31:0] d, input logic idle, output logic acc);
        @(negedge clk);
        chk("pending", pending, model_q.size());
        chk("in_ready", in_ready, model_q.size() != DEPTH);
        chk("empty", empty, model_q.size() == 0 && !pulse_now);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        tex_idle = idle;
        @(posedge clk);
        acc = 1'b0;
        if (!reset) begin
            acc = v && model_q.size() != DEPTH;
            pulse_now = model_q.size() != 0 && idle;
            if (pulse_now) exp_q.push_back(model_q.pop_front());
            if (acc) model_q.push_back('{a: a, d: d});
        end
    endtask

    // monitor: every cycle the DUT pulse must match the model's expectation exactly, else addr/data must hold
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            chk("out_valid", out_write_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_write_valid) begin
                    chk("out_addr", out_write_addr, e.a);
                    chk("out_data", out_write_data, e.d);
                end
                last_a = e.a;
                last_d = e.d;
            end else begin
                chk("hold_addr", out_write_addr, last_a);
                chk("hold_data", out_write_data, last_d);
            end
        end
    end

    initial begin
        logic acc;
        logic cv;
        logic [11:0] ca;
        logic [31:0] cd;
        ent_t busy_set [4];
        busy_set[0] = '{a: 12'h00F, d: 32'h2};
        busy_set[1] = '{a: 12'h010, d: 32'h8000};
        busy_set[2] = '{a: 12'h011, d: 32'h3};
        busy_set[3] = '{a: 12'h012, d: 32'h1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_empty", empty, 1);
        chk("rst_valid", out_write_valid, 0);
        chk("rst_addr", out_write_addr, 0);

        step(1'b1, 12'h010, 32'h1234, 1'b1, acc);
        chk("single_acc", acc, 1);
        repeat (4) step(1'b0, 12'h0, 32'h0, 1'b1, acc);

        for (int i = 0; i < 4; i++) step(1'b1, busy_set[i].a, busy_set[i].d, 1'b0, acc);
        repeat (3) begin
            step(1'b1, 12'h013, 32'h55, 1'b0, acc);
            chk("full_no_push", acc, 0);
        end
        step(1'b1, 12'h013, 32'h55, 1'b1, acc);
        chk("full_pop_no_push", acc, 0);
        step(1'b1, 12'h013, 32'h55, 1'b1, acc);
        chk("push_after_pop", acc, 1);
        repeat (6) step(1'b0, 12'h0, 32'h0, 1'b1, acc);

        for (int i = 0; i < 3; i++) step(1'b1, 12'h020 + 12'(i), 32'hA0 + 32'(i), 1'b0, acc);
        step(1'b0, 12'h0, 32'h0, 1'b1, acc);
        repeat (4) step(1'b0, 12'h0, 32'h0, 1'b0, acc);
        chk("toggle_pending", pending, 2);
        repeat (4) step(1'b0, 12'h0, 32'h0, 1'b1, acc);

        cv = 1'b0;
        ca = '0;
        cd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!cv) begin
                cv = 1'($urandom_range(0, 1));
                ca = 12'($urandom);
                cd = $urandom;
            end
            step(cv, ca, cd, 1'($urandom_range(0, 2) != 0), acc);
            if (acc) cv = 1'b0;
        end
        repeat (6) step(1'b0, 12'h0, 32'h0, 1'b1, acc);

        for (int i = 0; i < 3; i++) step(1'b1, 12'h030 + 12'(i), 32'hB0 + 32'(i), 1'b0, acc);
        step(1'b0, 12'h0, 32'h0, 1'b1, acc);
        #2;
        reset = 1'b1;
        model_q.delete();
        exp_q.delete();
        pulse_now = 1'b0;
        last_a = '0;
        last_d = '0;
        #1;
        chk("arst_valid", out_write_valid, 0);
        chk("arst_pending", pending, 0);
        chk("arst_empty", empty, 1);
        chk("arst_addr", out_write_addr, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) step(1'b0, 12'h0, 32'h0, 1'b1, acc);

        @(negedge clk);
        nb_idle  = 1'b0;
        nb_valid = 1'b1;
        nb_addr  = 12'h0A1;
        nb_data  = 32'hC1;
        @(negedge clk);
        chk("nb_valid_e0", nb_out_valid, 0);
        chk("nb_pending_e0", nb_pending, 1);
        nb_addr = 12'h0A2;
        nb_data = 32'hC2;
        @(negedge clk);
        nb_valid = 1'b0;
        chk("nb_valid_e1", nb_out_valid, 1);
        chk("nb_addr_e1", nb_out_addr, 12'h0A1);
        chk("nb_data_e1", nb_out_data, 32'hC1);
        @(negedge clk);
        chk("nb_valid_e2", nb_out_valid, 1);
        chk("nb_addr_e2", nb_out_addr, 12'h0A2);
        chk("nb_data_e2", nb_out_data, 32'hC2);
        @(negedge clk);
        chk("nb_valid_e3", nb_out_valid, 0);
        chk("nb_pending_e3", nb_pending, 0);
        chk("nb_empty_e3", nb_empty, 1);
        chk("nb_ready_e3", nb_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
